// File: rtl/rom_boot_loader.sv
// ROM boot loader: takes the index-0 ioctl byte stream and maps each 16 KB
// page to an SDRAM row and bank. Bytes are buffered in a small FIFO and
// written out one req/ack transaction per byte. The CPU is held in reset
// until the last byte of a load has been written.
//
// Handshake: mem_we is a level request. mem_addr, mem_bank and mem_din are
// stable while mem_we=1. A transfer completes on the clock edge where
// mem_we=1 and mem_ack=1, and mem_we drops on that same edge. A new request
// is issued only from mem_we=0, so there is always at least one idle cycle
// between requests. mem_ack seen while mem_we=0 is ignored.
module rom_boot_loader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic        mem_bank,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        rom_hold,
    output logic        done,
    output logic        overflow,
    output logic [15:0] dropped,
    output logic [1:0]  dbg_state
);

    // Encoding chosen so rom_hold is bit 0 of the state register.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_DRAIN = 2'b11,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_dl0_q;
    logic        r_dl_q;
    logic [31:0] r_fifo [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        r_mem_we;
    logic [22:0] r_mem_addr;
    logic        r_mem_bank;
    logic [7:0]  r_mem_din;
    logic        r_overflow;
    logic [15:0] r_dropped;

    logic        w_dl0;
    logic        w_dl0_rise;
    logic        w_dl_fall;
    logic        w_act;
    logic        w_mapped;
    logic [8:0]  w_row;
    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_entry;

    assign w_dl0      = ioctl_download & (ioctl_index == 8'd0);
    assign w_dl0_rise = w_dl0 & ~r_dl0_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;
    assign w_act      = w_dl0 & ioctl_wr;
    // Only pages 0..7 exist in the map.
    assign w_mapped   = (ioctl_addr[24:17] == 8'd0);

    assign w_count = r_wp - r_rp;
    assign w_full  = (w_count == L_FULL);
    assign w_empty = (r_wp == r_rp);
    assign w_pop   = ~r_mem_we & ~w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push  = w_act & w_mapped & (~w_full | w_pop);
    assign w_entry = {ioctl_addr[16], w_row, ioctl_addr[13:0], ioctl_dout};

    // Page-to-row lookup; pages 4..7 reuse the rows of 0..3 in bank 1.
    always_comb begin
        w_row = 9'h000;
        case (ioctl_addr[15:14])
            2'd0:    w_row = 9'h000;
            2'd1:    w_row = 9'h100;
            2'd2:    w_row = 9'h107;
            default: w_row = 9'h1ff;
        endcase
    end

    // Download edge detectors.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl0_q <= 1'b0;
            r_dl_q  <= 1'b0;
        end else begin
            r_dl0_q <= w_dl0;
            r_dl_q  <= ioctl_download;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_sys) begin
        if (w_push) r_fifo[r_wp[AW-1:0]] <= w_entry;
    end

    // FIFO pointers, sticky overflow and saturating drop counter.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= 16'd0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_act && w_mapped && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_act && !w_mapped && r_dropped != 16'hFFFF)
                r_dropped <= r_dropped + 16'd1;
        end
    end

    // SDRAM request register: load from the FIFO head, hold until ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= 23'd0;
            r_mem_bank <= 1'b0;
            r_mem_din  <= 8'd0;
        end else if (r_mem_we && mem_ack) begin
            r_mem_we <= 1'b0;
        end else if (w_pop) begin
            r_mem_we <= 1'b1;
            {r_mem_bank, r_mem_addr, r_mem_din} <= r_fifo[r_rp[AW-1:0]];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic; a new download during DRAIN resumes LOAD and
    // keeps whatever is still queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_dl0_rise) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_dl_fall)  w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_dl0_rise)                 w_state_nxt = S_LOAD;
                else if (w_empty && !r_mem_we)  w_state_nxt = S_DONE;
            end
            default: w_state_nxt = w_dl0_rise ? S_LOAD : S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        rom_hold = r_state[0];
        done     = (r_state == S_DONE);
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_bank  = r_mem_bank;
    assign mem_din   = r_mem_din;
    assign overflow  = r_overflow;
    assign dropped   = r_dropped;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: directed downloads. Every expected SDRAM write
// is pushed into exp_q as {bank, addr, data} and checked in order by a monitor
// when a new request appears.
module tb_rom_boot_loader;
  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic        mem_bank;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic        rom_hold;
  logic        done;
  logic        overflow;
  logic [15:0] dropped;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n_writes = 0;
  bit ack_en = 1'b0;
  int ack_dly = 2;

  rom_boot_loader #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_din(mem_din), .mem_ack(mem_ack), .rom_hold(rom_hold),
    .done(done), .overflow(overflow), .dropped(dropped),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic put_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    chk("hold_before_rise", rom_hold, 0);
    @(negedge clk_sys);
    chk("hold_after_rise", rom_hold, 1);
  endtask

  task automatic wait_done();
    int start_done;
    bit seen;
    bit hold_ok;
    start_done = done_cnt;
    seen = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk_sys);
      if (done) begin
        seen = 1'b1;
        chk("hold_in_done_cycle", rom_hold, 0);
      end else if (!rom_hold) begin
        hold_ok = 1'b0;
      end
    end
    chk("done_seen", seen, 1);
    chk("hold_until_done", hold_ok, 1);
    repeat (5) @(negedge clk_sys);
    chk("done_once", done_cnt - start_done, 1);
  endtask

  // SDRAM model: acks after ack_dly sampled cycles of mem_we.
  initial begin
    int hi_cnt;
    hi_cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!ack_en) begin
        hi_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        hi_cnt = 0;
      end else if (mem_we) begin
        hi_cnt++;
        if (hi_cnt >= ack_dly) begin
          mem_ack = 1'b1;
          n_writes++;
        end
      end else begin
        hi_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: compares each new request against exp_q and checks
  // that request fields hold steady while mem_we is high.
  initial begin
    logic        prev_we;
    logic [31:0] held;
    logic [31:0] e;
    prev_we = 1'b0;
    held = '0;
    forever begin
      @(negedge clk_sys);
      if (done) done_cnt++;
      if (mem_we && !prev_we) begin
        held = {mem_bank, mem_addr, mem_din};
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {mem_bank, mem_addr, mem_din}, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("req", {mem_bank, mem_addr, mem_din}, e);
        end
      end else if (mem_we && prev_we) begin
        chk("req_stable", {mem_bank, mem_addr, mem_din}, held);
      end
      prev_we = mem_we;
    end
  end

  initial begin
    int w0;
    bit seen;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_outputs", {mem_we, mem_addr, mem_bank, mem_din, rom_hold, done}, 32'd0);
    chk("rst_flags", {overflow, dropped}, 32'd0);
    chk("rst_state", dbg_state, 2'b00);

    // Test 1: four bytes, ack two cycles after each request.
    ack_en = 1'b1;
    ack_dly = 2;
    w0 = n_writes;
    start_dl();
    exp_q.push_back({1'b0, 23'h000000, 8'hAA});
    exp_q.push_back({1'b0, 23'h000001, 8'hBB});
    exp_q.push_back({1'b0, 23'h000002, 8'hCC});
    exp_q.push_back({1'b0, 23'h000003, 8'hDD});
    put_byte(25'h0, 8'hAA);
    put_byte(25'h1, 8'hBB);
    put_byte(25'h2, 8'hCC);
    put_byte(25'h3, 8'hDD);
    ioctl_download = 1'b0;
    wait_done();
    chk("t1_writes", n_writes - w0, 4);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Test 2: out-of-map byte dropped, page 5 byte mapped; N+2 latency.
    w0 = n_writes;
    start_dl();
    put_byte(25'h004_8005, 8'h5A);
    chk("t2_dropped", dropped, 16'd1);
    chk("t2_no_req_for_drop", mem_we, 0);
    exp_q.push_back({1'b1, 23'h400005, 8'h5A});
    put_byte(25'h001_4005, 8'h5A);
    chk("t2_lat_n1", mem_we, 0);
    @(negedge clk_sys);
    chk("t2_lat_n2", mem_we, 1);
    ioctl_download = 1'b0;
    wait_done();
    chk("t2_writes", n_writes - w0, 1);
    chk("t2_dropped_after", dropped, 16'd1);

    // Test 3: DEPTH+2 bytes with ack held off.
    ack_en = 1'b0;
    w0 = n_writes;
    start_dl();
    for (int i = 0; i < DEPTH + 1; i++)
      exp_q.push_back({1'b0, 23'h000100 + 23'(i), 8'h10 + 8'(i)});
    for (int i = 0; i < DEPTH + 2; i++)
      put_byte(25'h100 + 25'(i), 8'h10 + 8'(i));
    chk("t3_overflow", overflow, 1);
    chk("t3_head_in_regs", {mem_we, mem_din}, {1'b1, 8'h10});
    ack_en = 1'b1;
    ioctl_download = 1'b0;
    wait_done();
    chk("t3_writes", n_writes - w0, DEPTH + 1);
    chk("t3_overflow_sticky", overflow, 1);

    // Test 4: reset while a request is pending, ack in the same cycle.
    ack_en = 1'b0;
    start_dl();
    exp_q.push_back({1'b0, 23'h000020, 8'h77});
    put_byte(25'h20, 8'h77);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_we) seen = 1'b1;
      else @(negedge clk_sys);
    end
    chk("t4_req_seen", seen, 1);
    w0 = done_cnt;
    mem_ack = 1'b1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("t4_rst_outputs", {mem_we, mem_addr, mem_bank, mem_din, rom_hold, done}, 32'd0);
    chk("t4_rst_flags", {overflow, dropped}, 32'd0);
    mem_ack = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      if (mem_we || rom_hold) seen = 1'b1;
    end
    chk("t4_idle_after_rst", seen, 0);
    chk("t4_no_done", done_cnt - w0, 0);
    chk("t4_state", dbg_state, 2'b00);

    // Test 5: index 1 download is ignored.
    ack_en = 1'b1;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    put_byte(25'h0, 8'h11);
    put_byte(25'h004_8005, 8'h22);
    put_byte(25'h2, 8'h33);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_sys);
      if (mem_we || rom_hold) seen = 1'b1;
    end
    chk("t5_no_activity", seen, 0);
    chk("t5_dropped", dropped, 16'd0);
    chk("t5_state", dbg_state, 2'b00);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    @(negedge clk_sys);

    // Test 6: new download while draining keeps queued bytes.
    ack_dly = 3;
    w0 = n_writes;
    start_dl();
    exp_q.push_back({1'b0, 23'h7FC010, 8'h61});
    exp_q.push_back({1'b0, 23'h7FC011, 8'h62});
    exp_q.push_back({1'b0, 23'h7FC012, 8'h63});
    exp_q.push_back({1'b1, 23'h41C005, 8'h64});
    exp_q.push_back({1'b1, 23'h41C006, 8'h65});
    put_byte(25'h0_C010, 8'h61);
    put_byte(25'h0_C011, 8'h62);
    put_byte(25'h0_C012, 8'h63);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk("t6_drain", dbg_state, 2'b11);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("t6_reload", dbg_state, 2'b01);
    chk("t6_hold", rom_hold, 1);
    put_byte(25'h1_8005, 8'h64);
    put_byte(25'h1_8006, 8'h65);
    ioctl_download = 1'b0;
    wait_done();
    chk("t6_writes", n_writes - w0, 5);
    chk("t6_queue_empty", exp_q.size(), 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
